is_uart_tx_fsm: RTL and testbench

UART transmit framer, the transmit-side counterpart of the controller's receive FSM.
- Accepts one 8-bit byte per valid/ready handshake.
- Serialises it on txd_o as: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Bit timing comes from an external bit-rate strobe (tx_ce_i, one pulse per bit period) produced by the shared baud generator.
- Sits between the controller's TX holding register and the pad.

---
 rtl/is_pkg_uart_controller.sv | 38 +++
 rtl/is_uart_tx_fsm.sv | 146 ++++++++++++++
 tb/tb_is_uart_tx_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/is_pkg_uart_controller.sv
// Shared types and constants for the UART controller.
//   parity_t      - parity bit type selected per transmitter/receiver instance
//   tx_state_t    - transmit framer state encoding
//   parity_bit()  - parity bit for a latched data byte
package is_pkg_uart_controller;

    localparam int unsigned UART_DATA_W   = 8;
    localparam logic        UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_ODD   = 3'd1,
        PAR_EVEN  = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TSTRB = 3'd1,
        TDT   = 3'd2,
        TPARB = 3'd3,
        TSTB1 = 3'd4,
        TSTB2 = 3'd5,
        WEND  = 3'd6
    } tx_state_t;

    function automatic logic parity_bit(input parity_t mode,
                                        input logic [UART_DATA_W-1:0] data);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/is_uart_tx_fsm.sv
// UART transmit framer. Takes one byte per valid/ready handshake and serialises it as
// start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. Each bit
// advances on the external bit-period strobe.
// Ports:
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   tx_ce_i       bit-period strobe, single-cycle pulse
//   tx_data_i     byte to transmit, sampled only in the accept cycle
//   tx_data_en_i  byte valid
//   tx_rdy_o      ready; transfer when tx_data_en_i && tx_rdy_o
//   txd_o         serial line, idle high
//   txct_o        1 = line idle, 0 = frame in progress
//   tx_done_o     one-cycle pulse when the last stop bit has completed
module is_uart_tx_fsm
    import is_pkg_uart_controller::*;
#(
    parameter parity_t     PARITY_MODE = PAR_SPACE,
    parameter int unsigned STOP_BITS   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_ce_i,
    input  logic [UART_DATA_W-1:0] tx_data_i,
    input  logic                   tx_data_en_i,
    output logic                   tx_rdy_o,
    output logic                   txd_o,
    output logic                   txct_o,
    output logic                   tx_done_o
);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop_bits
        $error("is_uart_tx_fsm: STOP_BITS must be 1 or 2");
    end

    tx_state_t              state_q, state_d;
    logic [UART_DATA_W-1:0] sh_q, sh_d;
    // Unshifted copy of the byte; parity is taken from this, not from the shifter.
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   txd_q, txd_d;
    logic                   rdy_q, rdy_d;
    logic                   txct_q, txct_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        rdy_d     = rdy_q;
        txct_d    = txct_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A strobe coinciding with accept is ignored; the start bit waits for the next.
                if (tx_data_en_i) begin
                    sh_d      = tx_data_i;
                    data_d    = tx_data_i;
                    bit_cnt_d = '0;
                    rdy_d     = 1'b0;
                    txct_d    = 1'b0;
                    state_d   = TSTRB;
                end
            end
            TSTRB: begin
                if (tx_ce_i) begin
                    txd_d   = 1'b0;
                    state_d = TDT;
                end
            end
            TDT: begin
                if (tx_ce_i) begin
                    txd_d     = sh_q[0];
                    sh_d      = {1'b0, sh_q[UART_DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY_MODE == PAR_NONE) ? TSTB1 : TPARB;
                    end
                end
            end
            TPARB: begin
                if (tx_ce_i) begin
                    txd_d   = parity_bit(PARITY_MODE, data_q);
                    state_d = TSTB1;
                end
            end
            TSTB1: begin
                if (tx_ce_i) begin
                    txd_d   = 1'b1;
                    state_d = (STOP_BITS == 2) ? TSTB2 : WEND;
                end
            end
            TSTB2: begin
                if (tx_ce_i) begin
                    txd_d   = 1'b1;
                    state_d = WEND;
                end
            end
            WEND: begin
                // Strobe here marks the end of the last stop bit.
                if (tx_ce_i) begin
                    done_d  = 1'b1;
                    rdy_d   = 1'b1;
                    txct_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = UART_IDLE_LVL;
                rdy_d   = 1'b1;
                txct_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
            txd_q     <= UART_IDLE_LVL;
            rdy_q     <= 1'b1;
            txct_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            rdy_q     <= rdy_d;
            txct_q    <= txct_d;
            done_q    <= done_d;
        end
    end

    assign txd_o     = txd_q;
    assign tx_rdy_o  = rdy_q;
    assign txct_o    = txct_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_is_uart_tx_fsm.sv
// Bench for is_uart_tx_fsm. Four instances share clock, reset, strobe and data:
//   0: PAR_SPACE, 2 stops   1: PAR_ODD, 2 stops   2: PAR_EVEN, 2 stops   3: PAR_NONE, 1 stop
// Expected line bits are queued when a byte is accepted and compared strobe by strobe.
module tb_is_uart_tx_fsm;
    import is_pkg_uart_controller::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_ce;
    logic [7:0] tx_data;
    logic [3:0] en;
    logic [3:0] rdy, txd, txct, done;

    parity_t par_mode [4];
    int      stops    [4];

    logic    exp_q [$];
    int      checks   = 0;
    int      failures = 0;

    always #5 clk = ~clk;

    is_uart_tx_fsm #(.PARITY_MODE(PAR_SPACE), .STOP_BITS(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .tx_ce_i(tx_ce), .tx_data_i(tx_data),
        .tx_data_en_i(en[0]), .tx_rdy_o(rdy[0]), .txd_o(txd[0]), .txct_o(txct[0]),
        .tx_done_o(done[0])
    );
    is_uart_tx_fsm #(.PARITY_MODE(PAR_ODD), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .tx_ce_i(tx_ce), .tx_data_i(tx_data),
        .tx_data_en_i(en[1]), .tx_rdy_o(rdy[1]), .txd_o(txd[1]), .txct_o(txct[1]),
        .tx_done_o(done[1])
    );
    is_uart_tx_fsm #(.PARITY_MODE(PAR_EVEN), .STOP_BITS(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .tx_ce_i(tx_ce), .tx_data_i(tx_data),
        .tx_data_en_i(en[2]), .tx_rdy_o(rdy[2]), .txd_o(txd[2]), .txct_o(txct[2]),
        .tx_done_o(done[2])
    );
    is_uart_tx_fsm #(.PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .tx_ce_i(tx_ce), .tx_data_i(tx_data),
        .tx_data_en_i(en[3]), .tx_rdy_o(rdy[3]), .txd_o(txd[3]), .txct_o(txct[3]),
        .tx_done_o(done[3])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe();
        tx_ce = 1'b1;
        tick();
        tx_ce = 1'b0;
    endtask

    // Reference frame: start, data LSB first, parity by counting ones, stop bits.
    task automatic push_frame(input int k, input logic [7:0] b);
        int ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            if (b[i]) ones++;
        end
        case (par_mode[k])
            PAR_ODD:   exp_q.push_back((ones % 2) == 0);
            PAR_EVEN:  exp_q.push_back((ones % 2) == 1);
            PAR_MARK:  exp_q.push_back(1'b1);
            PAR_SPACE: exp_q.push_back(1'b0);
            default: ;
        endcase
        for (int s = 0; s < stops[k]; s++) exp_q.push_back(1'b1);
    endtask

    task automatic accept(input int k, input logic [7:0] b, input logic ce_too);
        tx_data = b;
        en[k]   = 1'b1;
        tx_ce   = ce_too;
        tick();
        en[k]   = 1'b0;
        tx_ce   = 1'b0;
        check("accept_rdy", rdy[k], 1'b0);
        check("accept_txct", txct[k], 1'b0);
        check("accept_txd", txd[k], 1'b1);
        push_frame(k, b);
    endtask

    // Drain the queued frame, then the closing strobe that must pulse done.
    task automatic run_frame(input int k, input int stall_at, input int inject_at);
        int   n = exp_q.size();
        logic e;
        for (int i = 0; i < n; i++) begin
            if (i == inject_at) begin
                en[k]   = 1'b1;
                tx_data = 8'hFF;
                idle(15);
                en[k]   = 1'b0;
            end else begin
                idle(15);
            end
            strobe();
            e = exp_q.pop_front();
            check("line_bit", txd[k], e);
            check("done_early", done[k], 1'b0);
            if (i == stall_at) begin
                idle(100);
                check("stall_txd", txd[k], e);
                check("stall_done", done[k], 1'b0);
                check("stall_rdy", rdy[k], 1'b0);
            end
        end
        idle(15);
        strobe();
        check("done_pulse", done[k], 1'b1);
        check("done_rdy", rdy[k], 1'b1);
        check("done_txct", txct[k], 1'b1);
        check("done_txd", txd[k], 1'b1);
        tick();
        check("done_width", done[k], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        par_mode = '{PAR_SPACE, PAR_ODD, PAR_EVEN, PAR_NONE};
        stops    = '{2, 2, 2, 1};
        rst      = 1'b1;
        tx_ce    = 1'b0;
        tx_data  = 8'h00;
        en       = 4'b0000;
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rst_txd", txd[k], 1'b1);
            check("rst_rdy", rdy[k], 1'b1);
            check("rst_txct", txct[k], 1'b1);
            check("rst_done", done[k], 1'b0);
        end

        // Reset mid-data while the line is low.
        accept(0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(15);
            strobe();
            check("pre_rst_bit", txd[0], exp_q.pop_front());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_txd", txd[0], 1'b1);
        check("midrst_rdy", rdy[0], 1'b1);
        check("midrst_txct", txct[0], 1'b1);
        check("midrst_done", done[0], 1'b0);
        idle(3);

        // Default parameters, 0xA5.
        accept(0, 8'hA5, 1'b0);
        run_frame(0, -1, -1);

        // Parity variants and the no-parity, single-stop frame.
        accept(1, 8'h03, 1'b0);
        run_frame(1, -1, -1);
        accept(1, 8'h01, 1'b0);
        run_frame(1, -1, -1);
        accept(2, 8'h03, 1'b0);
        run_frame(2, -1, -1);
        accept(2, 8'h01, 1'b0);
        run_frame(2, -1, -1);
        accept(3, 8'h00, 1'b0);
        run_frame(3, -1, -1);

        // Back-to-back with valid held high.
        tx_data = 8'h55;
        en[0]   = 1'b1;
        tick();
        check("b2b_rdy0", rdy[0], 1'b0);
        push_frame(0, 8'h55);
        tx_data = 8'hAA;
        run_frame(0, -1, -1);
        check("b2b_rdy1", rdy[0], 1'b0);
        check("b2b_txct1", txct[0], 1'b0);
        en[0] = 1'b0;
        push_frame(0, 8'hAA);
        run_frame(0, -1, -1);

        // Valid pulsed mid-frame and data changed after accept.
        accept(0, 8'h12, 1'b0);
        tx_data = 8'h34;
        run_frame(0, -1, 4);
        idle(2);
        check("ignored_txct", txct[0], 1'b1);
        check("ignored_rdy", rdy[0], 1'b1);

        // Strobe in the accept cycle; long strobe gap inside the data bits.
        accept(0, 8'h96, 1'b1);
        idle(3);
        check("ce_accept_txd", txd[0], 1'b1);
        run_frame(0, 4, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
